// File: rtl/pmod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmod_pkg
// Description : Shared constants and types for the PMOD receive path.
//               Holds the power-field width, the pin map of the raw PMOD
//               vector and the throw-acceptance state type.
// Revision    : 1.0 - initial release
// ============================================================================
package pmod_pkg;

    localparam int POWER_W     = 5;

    // Raw pin map: [0] p1_ready, [1] p2_ready, [POWER_W+1:2] power,
    // [POWER_W+2] throw
    localparam int PIN_P1      = 0;
    localparam int PIN_P2      = 1;
    localparam int PIN_PWR_LSB = 2;
    localparam int PIN_THROW   = POWER_W + 2;

    typedef enum logic [0:0] {
        HOLD = 1'b0,
        IDLE = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/pmod_if.sv
`default_nettype none
// ============================================================================
// Module      : pmod_if
// Description : Game-signal bundle produced by the PMOD receiver. The
//               receiver drives it through modport out, local game logic
//               reads it through modport in.
// Revision    : 1.0 - initial release
// ============================================================================
interface pmod_if
    import pmod_pkg::*;
();

    logic               player1_ready;
    logic               player2_ready;
    logic [POWER_W-1:0] power;
    logic               throw_flag;

    modport out (
        output player1_ready,
        output player2_ready,
        output power,
        output throw_flag
    );

    modport in (
        input  player1_ready,
        input  player2_ready,
        input  power,
        input  throw_flag
    );

endinterface
`default_nettype wire

// File: rtl/pmod_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : pmod_sync_filter
// Description : Per-bit multi-flop synchroniser followed by a whole-vector
//               stability filter. The filtered vector only takes a new value
//               once the synchronised vector has held it for STABLE_CYCLES
//               consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_sync_filter #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_pins,
    output logic      [WIDTH-1:0] o_filt,
    output logic      [WIDTH-1:0] o_filt_next,
    output logic                  o_load
);

    localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_filt;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] w_sync;
    logic [7:0]       w_cnt_next;
    logic             w_load;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Plain flop chain per pin; nothing sits between stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Counter holds the number of repeats after the first sighting, so the
    // vector has been seen for r_cnt+1 cycles; any bit change restarts it
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_sync != r_prev) begin
            w_cnt_next = '0;
        end else if (r_cnt != c_STABLE) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    assign w_load      = (w_cnt_next >= (c_STABLE - 8'd1));
    assign o_filt_next = w_load ? w_sync : r_filt;
    assign o_filt      = r_filt;
    assign o_load      = w_load;

    // Track the previous synchronised vector, the run length and the filtered vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_cnt  <= '0;
            r_filt <= '0;
        end else begin
            r_prev <= w_sync;
            r_cnt  <= w_cnt_next;
            r_filt <= o_filt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pmod_rx.sv
`default_nettype none
// ============================================================================
// Module      : pmod_rx
// Description : Receiving end of the inter-board PMOD link. Synchronises and
//               filters the raw pins, then runs the throw-acceptance FSM that
//               emits a one-cycle accept pulse (with captured power) or a
//               one-cycle reject pulse.
//               Optional macro PMOD_RX_CNT_EN adds a saturating 8-bit count
//               of accepted throws on port throw_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_rx #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int POWER_W       = pmod_pkg::POWER_W
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [POWER_W+2:0] pmod_pins,
    pmod_if.out                     rx,
    output logic                    throw_reject
`ifdef PMOD_RX_CNT_EN
    ,
    output logic [7:0]              throw_cnt
`endif
);

    localparam int c_W = POWER_W + 3;

    logic [c_W-1:0]       w_filt;
    logic [c_W-1:0]       w_filt_next;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_unused;

    pmod_pkg::rx_state_t  r_state;
    logic [POWER_W-1:0]   r_power;
    logic                 r_flag;
    logic                 r_reject;

    pmod_sync_filter #(
        .WIDTH         (c_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .i_pins      (pmod_pins),
        .o_filt      (w_filt),
        .o_filt_next (w_filt_next),
        .o_load      (w_load)
    );

    // Decisions use the vector being loaded this cycle so the pulses line up
    // with the filtered vector instead of trailing it by a cycle
    assign w_accept = w_filt_next[pmod_pkg::PIN_P1] & w_filt_next[pmod_pkg::PIN_P2]
                    & (|w_filt_next[pmod_pkg::PIN_PWR_LSB +: POWER_W]);

    // Power bits of the settled vector are only consumed via w_filt_next
    assign w_unused = ^w_filt[pmod_pkg::PIN_PWR_LSB +: POWER_W];

    // HOLD leaves only on a real filter load with throw low, so a throw that
    // was already high through reset can never register as a rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= pmod_pkg::HOLD;
            r_power  <= '0;
            r_flag   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_flag   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                pmod_pkg::HOLD: begin
                    if (w_load && !w_filt_next[pmod_pkg::PIN_THROW]) begin
                        r_state <= pmod_pkg::IDLE;
                    end
                end
                pmod_pkg::IDLE: begin
                    if (w_filt_next[pmod_pkg::PIN_THROW] && !w_filt[pmod_pkg::PIN_THROW]) begin
                        r_state <= pmod_pkg::HOLD;
                        if (w_accept) begin
                            r_power <= w_filt_next[pmod_pkg::PIN_PWR_LSB +: POWER_W];
                            r_flag  <= 1'b1;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                default: r_state <= pmod_pkg::HOLD;
            endcase
        end
    end

    assign rx.player1_ready = w_filt[pmod_pkg::PIN_P1];
    assign rx.player2_ready = w_filt[pmod_pkg::PIN_P2];
    assign rx.power         = r_power;
    assign rx.throw_flag    = r_flag;
    assign throw_reject     = r_reject;

`ifdef PMOD_RX_CNT_EN
    logic [7:0] r_cnt;

    // Accepted-throw tally, saturating so it never wraps back to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_flag && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign throw_cnt = r_cnt;
`endif

endmodule
`default_nettype wire
